operand_fetch: RTL and testbench

//  Issue stage between decode and execute. Accepts one decoded instruction per cycle over a

---
 rtl/riscv_pkg.sv | 12 +
 rtl/operand_bypass.sv | 34 +++
 rtl/operand_fetch.sv | 153 +++++++++++++++
 tb/tb_operand_fetch.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared core constants and types for the issue path.
package riscv_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned REG_W = 5;

    typedef logic [REG_W-1:0] rf_idx_t;
    typedef logic [XLEN-1:0]  xlen_t;

    localparam rf_idx_t REG_ZERO = '0;

endpackage

// File: rtl/operand_bypass.sv
// Per-operand resolve and writeback-forward logic for the operand fetch stage.
module operand_bypass #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned REG_W = 5
) (
    input  logic [REG_W-1:0] rs,
    input  logic [XLEN-1:0]  rf_val,
    input  logic             fwd_flag,
    input  logic [XLEN-1:0]  fwd_data,
    input  logic [REG_W-1:0] rd_idx,
    input  logic             wb_en,
    input  logic [REG_W-1:0] wb_idx,
    input  logic [XLEN-1:0]  wb_data,
    output logic [XLEN-1:0]  value,
    output logic [XLEN-1:0]  value_wb,
    output logic             nxt_flag,
    output logic [XLEN-1:0]  nxt_data
);
    import riscv_pkg::*;

    logic rs_zero;
    logic rs_hit;

    always_comb begin
        rs_zero  = (rs == REG_W'(REG_ZERO));
        rs_hit   = wb_en && (wb_idx == rs) && !rs_zero;
        value    = rs_zero ? '0 : (fwd_flag ? fwd_data : rf_val);
        value_wb = rs_hit ? wb_data : value;
        // The regfile returns pre-write data when it is written on the read edge.
        nxt_flag = wb_en && (wb_idx == rd_idx) && (rd_idx != REG_W'(REG_ZERO));
        nxt_data = wb_data;
    end

endmodule

// File: rtl/operand_fetch.sv
// Issue stage: read-in-flight slot P1 plus output slot, with writeback forwarding.
module operand_fetch #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned REG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [XLEN-1:0]  in_instr,
    input  logic [REG_W-1:0] in_rs1,
    input  logic [REG_W-1:0] in_rs2,
    output logic [REG_W-1:0] rf_read_a,
    output logic [REG_W-1:0] rf_read_b,
    input  logic [XLEN-1:0]  rf_a,
    input  logic [XLEN-1:0]  rf_b,
    input  logic             wb_en,
    input  logic [REG_W-1:0] wb_idx,
    input  logic [XLEN-1:0]  wb_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [XLEN-1:0]  out_instr,
    output logic [XLEN-1:0]  out_rs1_val,
    output logic [XLEN-1:0]  out_rs2_val
);
    import riscv_pkg::*;

    logic             p1_valid;
    logic [XLEN-1:0]  p1_pc;
    logic [XLEN-1:0]  p1_instr;
    logic [REG_W-1:0] p1_rs1;
    logic [REG_W-1:0] p1_rs2;
    logic             p1_fa;
    logic             p1_fb;
    logic [XLEN-1:0]  p1_fa_data;
    logic [XLEN-1:0]  p1_fb_data;

    logic [REG_W-1:0] out_rs1;
    logic [REG_W-1:0] out_rs2;

    logic             adv;
    logic             stall;
    logic             accept;
    logic             hold_hit_a;
    logic             hold_hit_b;

    logic [XLEN-1:0]  a_value;
    logic [XLEN-1:0]  a_value_wb;
    logic             a_nxt_flag;
    logic [XLEN-1:0]  a_nxt_data;
    logic [XLEN-1:0]  b_value;
    logic [XLEN-1:0]  b_value_wb;
    logic             b_nxt_flag;
    logic [XLEN-1:0]  b_nxt_data;

    always_comb begin
        adv        = p1_valid && (!out_valid || out_ready);
        stall      = p1_valid && !adv;
        in_ready   = !stall;
        accept     = in_valid && in_ready;
        rf_read_a  = stall ? p1_rs1 : in_rs1;
        rf_read_b  = stall ? p1_rs2 : in_rs2;
        hold_hit_a = wb_en && (wb_idx == out_rs1) && (out_rs1 != REG_W'(REG_ZERO));
        hold_hit_b = wb_en && (wb_idx == out_rs2) && (out_rs2 != REG_W'(REG_ZERO));
    end

    operand_bypass #(.XLEN(XLEN), .REG_W(REG_W)) u_byp_a (
        .rs       (p1_rs1),
        .rf_val   (rf_a),
        .fwd_flag (p1_fa),
        .fwd_data (p1_fa_data),
        .rd_idx   (rf_read_a),
        .wb_en    (wb_en),
        .wb_idx   (wb_idx),
        .wb_data  (wb_data),
        .value    (a_value),
        .value_wb (a_value_wb),
        .nxt_flag (a_nxt_flag),
        .nxt_data (a_nxt_data)
    );

    operand_bypass #(.XLEN(XLEN), .REG_W(REG_W)) u_byp_b (
        .rs       (p1_rs2),
        .rf_val   (rf_b),
        .fwd_flag (p1_fb),
        .fwd_data (p1_fb_data),
        .rd_idx   (rf_read_b),
        .wb_en    (wb_en),
        .wb_idx   (wb_idx),
        .wb_data  (wb_data),
        .value    (b_value),
        .value_wb (b_value_wb),
        .nxt_flag (b_nxt_flag),
        .nxt_data (b_nxt_data)
    );

    // Forward flags track whichever index is presented to the regfile this edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p1_valid   <= 1'b0;
            p1_pc      <= '0;
            p1_instr   <= '0;
            p1_rs1     <= '0;
            p1_rs2     <= '0;
            p1_fa      <= 1'b0;
            p1_fb      <= 1'b0;
            p1_fa_data <= '0;
            p1_fb_data <= '0;
        end else begin
            p1_fa      <= a_nxt_flag;
            p1_fb      <= b_nxt_flag;
            p1_fa_data <= a_nxt_data;
            p1_fb_data <= b_nxt_data;
            if (accept) begin
                p1_valid <= 1'b1;
                p1_pc    <= in_pc;
                p1_instr <= in_instr;
                p1_rs1   <= in_rs1;
                p1_rs2   <= in_rs2;
            end else if (adv) begin
                p1_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid   <= 1'b0;
            out_pc      <= '0;
            out_instr   <= '0;
            out_rs1     <= '0;
            out_rs2     <= '0;
            out_rs1_val <= '0;
            out_rs2_val <= '0;
        end else if (adv) begin
            out_valid   <= 1'b1;
            out_pc      <= p1_pc;
            out_instr   <= p1_instr;
            out_rs1     <= p1_rs1;
            out_rs2     <= p1_rs2;
            out_rs1_val <= a_value_wb;
            out_rs2_val <= b_value_wb;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end else if (out_valid) begin
            if (hold_hit_a) out_rs1_val <= wb_data;
            if (hold_hit_b) out_rs2_val <= wb_data;
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a registered-read regfile model.
module tb_operand_fetch;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [4:0]  rf_read_a;
    logic [4:0]  rf_read_b;
    logic [31:0] rf_a;
    logic [31:0] rf_b;
    logic        wb_en;
    logic [4:0]  wb_idx;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [31:0] out_rs1_val;
    logic [31:0] out_rs2_val;

    logic [31:0] regs [32];
    int checks;
    int failures;

    operand_fetch #(.XLEN(32), .REG_W(5)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_pc       (in_pc),
        .in_instr    (in_instr),
        .in_rs1      (in_rs1),
        .in_rs2      (in_rs2),
        .rf_read_a   (rf_read_a),
        .rf_read_b   (rf_read_b),
        .rf_a        (rf_a),
        .rf_b        (rf_b),
        .wb_en       (wb_en),
        .wb_idx      (wb_idx),
        .wb_data     (wb_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_instr   (out_instr),
        .out_rs1_val (out_rs1_val),
        .out_rs2_val (out_rs2_val)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_val(input int unsigned i);
        return 32'h1000_0000 + 32'(i);
    endfunction

    // Regfile: registered read, x0 never written and left undefined.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 1; i < 32; i++) regs[i] <= init_val(i);
            regs[0] <= 'x;
            regs[3] <= 32'h11;
            regs[4] <= 32'h22;
        end else if (wb_en && wb_idx != 5'd0) begin
            regs[wb_idx] <= wb_data;
        end
        rf_a <= regs[rf_read_a];
        rf_b <= regs[rf_read_b];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive_in(input logic [31:0] pc, input logic [31:0] instr,
                            input logic [4:0] rs1, input logic [4:0] rs2);
        in_valid = 1'b1;
        in_pc    = pc;
        in_instr = instr;
        in_rs1   = rs1;
        in_rs2   = rs2;
    endtask

    task automatic drive_wb(input logic [4:0] idx, input logic [31:0] data);
        wb_en   = 1'b1;
        wb_idx  = idx;
        wb_data = data;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b1;
        in_valid = 1'b0;
        in_pc = '0;
        in_instr = '0;
        in_rs1 = '0;
        in_rs2 = '0;
        wb_en = 1'b0;
        wb_idx = '0;
        wb_data = '0;
        out_ready = 1'b1;

        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_pc", out_pc, 0);
        reset = 1'b0;

        // basic issue, 2-cycle latency
        @(negedge clk);
        drive_in(32'h100, 32'hA1, 5'd3, 5'd4);
        @(negedge clk);
        in_valid = 1'b0;
        chk("t1_latency", out_valid, 0);
        @(negedge clk);
        chk("t1_valid", out_valid, 1);
        chk("t1_rs1", out_rs1_val, 32'h11);
        chk("t1_rs2", out_rs2_val, 32'h22);
        chk("t1_pc", out_pc, 32'h100);
        chk("t1_instr", out_instr, 32'hA1);

        // same-edge write on issue
        @(negedge clk);
        chk("t2_cleared", out_valid, 0);
        drive_in(32'h200, 32'hA2, 5'd5, 5'd4);
        drive_wb(5'd5, 32'hDEAD);
        @(negedge clk);
        in_valid = 1'b0;
        wb_en = 1'b0;
        @(negedge clk);
        chk("t2_valid", out_valid, 1);
        chk("t2_rs1_fwd", out_rs1_val, 32'hDEAD);
        chk("t2_rs2", out_rs2_val, 32'h22);

        // held output with writeback update, stalled P1 with re-read forward
        @(negedge clk);
        out_ready = 1'b0;
        drive_in(32'h300, 32'hA3, 5'd3, 5'd4);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("t3_valid", out_valid, 1);
        chk("t3_rs1", out_rs1_val, 32'h11);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t3_hold_valid", out_valid, 1);
            chk("t3_hold_pc", out_pc, 32'h300);
        end
        drive_wb(5'd3, 32'h99);
        @(negedge clk);
        wb_en = 1'b0;
        chk("t3_upd_rs1", out_rs1_val, 32'h99);
        chk("t3_upd_rs2", out_rs2_val, 32'h22);
        chk("t3_upd_pc", out_pc, 32'h300);
        chk("t3_upd_instr", out_instr, 32'hA3);
        drive_in(32'h310, 32'hA4, 5'd4, 5'd3);
        @(negedge clk);
        in_valid = 1'b0;
        chk("t3_stall_ready", in_ready, 0);
        drive_wb(5'd4, 32'h44);
        @(negedge clk);
        wb_en = 1'b0;
        chk("t3_hold_rs2_upd", out_rs2_val, 32'h44);
        chk("t3_hold_pc2", out_pc, 32'h300);
        out_ready = 1'b1;
        @(negedge clk);
        chk("t3_adv_valid", out_valid, 1);
        chk("t3_adv_pc", out_pc, 32'h310);
        chk("t3_adv_rs1_fwd", out_rs1_val, 32'h44);
        chk("t3_adv_rs2", out_rs2_val, 32'h99);

        // back-to-back throughput
        @(negedge clk);
        for (int c = 0; c < 10; c++) begin
            if (c >= 2) begin
                chk("t4_valid", out_valid, 1);
                chk("t4_pc", out_pc, 32'h1000 + 32'(4 * (c - 2)));
                chk("t4_rs1", out_rs1_val, init_val(8 + c - 2));
                chk("t4_rs2", out_rs2_val, init_val(16 + c - 2));
            end
            if (c < 8) begin
                chk("t4_in_ready", in_ready, 1);
                drive_in(32'h1000 + 32'(4 * c), 32'hB0 + 32'(c), 5'(8 + c), 5'(16 + c));
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end

        // x0 reads zero, ignores writes to index 0
        drive_in(32'h500, 32'hA5, 5'd0, 5'd8);
        drive_wb(5'd0, 32'h5);
        @(negedge clk);
        in_valid = 1'b0;
        wb_en = 1'b0;
        @(negedge clk);
        chk("t5_valid", out_valid, 1);
        chk("t5_rs1_zero", out_rs1_val, 32'h0);
        chk("t5_rs2", out_rs2_val, init_val(8));

        // reset with both slots full
        @(negedge clk);
        out_ready = 1'b0;
        drive_in(32'h600, 32'hA6, 5'd3, 5'd4);
        @(negedge clk);
        drive_in(32'h610, 32'hA7, 5'd5, 5'd6);
        @(negedge clk);
        in_valid = 1'b0;
        chk("t6_full_valid", out_valid, 1);
        chk("t6_full_ready", in_ready, 0);
        #1 reset = 1'b1;
        #1;
        chk("t6_rst_valid", out_valid, 0);
        chk("t6_rst_ready", in_ready, 1);
        chk("t6_rst_rs1", out_rs1_val, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t6_no_output", out_valid, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
